// File: rtl/vdg_pkg.sv
// Shared definitions for the VDG display-address path.
// Mode encoding, default geometry and per-mode bytes/repeat lookup.
package vdg_pkg;

    // Latched display mode: bit 3 is AnG, bits 2:0 are GM.
    // Alpha ignores GM, so it always collapses to a single code.
    typedef enum logic [3:0] {
        MODE_ALPHA = 4'b0000,
        MODE_G0    = 4'b1000,
        MODE_G1    = 4'b1001,
        MODE_G2    = 4'b1010,
        MODE_G3    = 4'b1011,
        MODE_G4    = 4'b1100,
        MODE_G5    = 4'b1101,
        MODE_G6    = 4'b1110,
        MODE_G7    = 4'b1111
    } vdg_mode_t;

    localparam int unsigned VDG_ADDR_WIDTH   = 13;
    localparam int unsigned VDG_ALPHA_ROWS   = 12;
    localparam int unsigned VDG_NARROW_BYTES = 16;
    localparam int unsigned VDG_WIDE_BYTES   = 32;
    localparam int unsigned VDG_CNT_WIDTH    = 4;

    localparam int unsigned VDG_REP_TRIPLE = 3;
    localparam int unsigned VDG_REP_DOUBLE = 2;
    localparam int unsigned VDG_REP_SINGLE = 1;

    function automatic vdg_mode_t vdg_mode(
        input logic       ang,
        input logic [2:0] gm
    );
        vdg_mode_t m;
        m = MODE_ALPHA;
        if (ang) begin
            m = vdg_mode_t'({1'b1, gm});
        end
        return m;
    endfunction

    function automatic int unsigned vdg_line_bytes(
        input logic        ang,
        input logic [2:0]  gm,
        input int unsigned narrow = VDG_NARROW_BYTES,
        input int unsigned wide   = VDG_WIDE_BYTES
    );
        int unsigned b;
        b = wide;
        if (ang) begin
            case (gm)
                3'd0, 3'd1, 3'd3, 3'd5: b = narrow;
                default:                b = wide;
            endcase
        end
        return b;
    endfunction

    function automatic int unsigned vdg_line_repeat(
        input logic        ang,
        input logic [2:0]  gm,
        input int unsigned alpha_rows = VDG_ALPHA_ROWS
    );
        int unsigned r;
        r = alpha_rows;
        if (ang) begin
            case (gm)
                3'd0, 3'd1, 3'd2: r = VDG_REP_TRIPLE;
                3'd3, 3'd4:       r = VDG_REP_DOUBLE;
                default:          r = VDG_REP_SINGLE;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/vdg_mode_decode.sv
// Combinational mode decoder: AnG/GM -> line length and line repeat.
// Ports: ang_i, gm_i (mode select) -> bytes_o (bytes/line), rpt_o (lines/group).
module vdg_mode_decode
    import vdg_pkg::*;
#(
    parameter int unsigned ALPHA_ROWS   = VDG_ALPHA_ROWS,
    parameter int unsigned NARROW_BYTES = VDG_NARROW_BYTES,
    parameter int unsigned WIDE_BYTES   = VDG_WIDE_BYTES,
    parameter int unsigned CNT_WIDTH    = VDG_CNT_WIDTH,
    parameter int unsigned BYTES_W      = $clog2(WIDE_BYTES + 1)
) (
    input  logic               ang_i,
    input  logic [2:0]         gm_i,
    output logic [BYTES_W-1:0] bytes_o,
    output logic [CNT_WIDTH:0] rpt_o
);

    localparam int unsigned RW = CNT_WIDTH + 1;

    assign bytes_o = BYTES_W'(vdg_line_bytes(ang_i, gm_i, NARROW_BYTES, WIDE_BYTES));
    assign rpt_o   = RW'(vdg_line_repeat(ang_i, gm_i, ALPHA_ROWS));

endmodule

// File: rtl/vdg_address_generator.sv
// Mode-aware display address generator for the 6847-compatible VDG.
// Ports: clk, reset (sync, active-high); strobes frame_start/line_end/byte_tick;
//   mode AnG/GM; start_addr (frame base, used with VDG_START_OFFSET_EN);
//   outputs DA (registered address), row (repeat/char row), RP, overrun pulses.
// Build option: define VDG_START_OFFSET_EN to start each frame at start_addr.
module vdg_address_generator
    import vdg_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 13,
    parameter int unsigned ALPHA_ROWS   = 12,
    parameter int unsigned NARROW_BYTES = 16,
    parameter int unsigned WIDE_BYTES   = 32,
    parameter int unsigned CNT_WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  line_end,
    input  logic                  byte_tick,
    input  logic                  AnG,
    input  logic [2:0]            GM,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    output logic [ADDR_WIDTH-1:0] DA,
    output logic [CNT_WIDTH-1:0]  row,
    output logic                  RP,
    output logic                  overrun
);

    localparam int unsigned BYTES_W = $clog2(WIDE_BYTES + 1);
    localparam int unsigned RW      = CNT_WIDTH + 1;

    vdg_mode_t             mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] da_q, da_d;
    logic [CNT_WIDTH-1:0]  row_q, row_d;
    logic                  rp_q, rp_d;
    logic                  ovr_q, ovr_d;

    // Mode presented on the inputs (takes effect at a strobe)
    vdg_mode_t          in_mode;
    logic [BYTES_W-1:0] in_bytes;
    logic [RW-1:0]      in_rpt;

    // Mode currently latched for the line in progress
    logic [BYTES_W-1:0] cur_bytes;
    logic [RW-1:0]      cur_rpt_unused;

    logic [ADDR_WIDTH-1:0] frame_base;
    logic [ADDR_WIDTH-1:0] idx_inc;
    logic [RW-1:0]         row_inc;
    logic                  group_done;
    logic                  line_full;

    assign in_mode = vdg_mode(AnG, GM);

    vdg_mode_decode #(
        .ALPHA_ROWS  (ALPHA_ROWS),
        .NARROW_BYTES(NARROW_BYTES),
        .WIDE_BYTES  (WIDE_BYTES),
        .CNT_WIDTH   (CNT_WIDTH),
        .BYTES_W     (BYTES_W)
    ) u_dec_in (
        .ang_i  (AnG),
        .gm_i   (GM),
        .bytes_o(in_bytes),
        .rpt_o  (in_rpt)
    );

    vdg_mode_decode #(
        .ALPHA_ROWS  (ALPHA_ROWS),
        .NARROW_BYTES(NARROW_BYTES),
        .WIDE_BYTES  (WIDE_BYTES),
        .CNT_WIDTH   (CNT_WIDTH),
        .BYTES_W     (BYTES_W)
    ) u_dec_cur (
        .ang_i  (mode_q[3]),
        .gm_i   (mode_q[2:0]),
        .bytes_o(cur_bytes),
        .rpt_o  (cur_rpt_unused)
    );

`ifdef VDG_START_OFFSET_EN
    assign frame_base = start_addr;
`else
    logic unused_start_addr;
    assign unused_start_addr = ^start_addr;
    assign frame_base        = '0;
`endif

    assign idx_inc = idx_q + ADDR_WIDTH'(1);
    assign row_inc = {1'b0, row_q} + RW'(1);

    // ">=" rather than "==" so that a switch to a mode with fewer
    // repeats, while row already exceeds it, closes the group at once.
    assign group_done = (row_inc >= in_rpt);

    // Last byte of the line already reached: further ticks are dropped.
    assign line_full = (idx_inc >= ADDR_WIDTH'(cur_bytes));

    // Next-state: strobes in strict priority, lower ones dropped.
    always_comb begin
        mode_d = mode_q;
        base_d = base_q;
        idx_d  = idx_q;
        row_d  = row_q;
        rp_d   = 1'b0;
        ovr_d  = 1'b0;
        if (frame_start) begin
            mode_d = in_mode;
            base_d = frame_base;
            idx_d  = '0;
            row_d  = '0;
        end else if (line_end) begin
            mode_d = in_mode;
            idx_d  = '0;
            if (group_done) begin
                row_d  = '0;
                base_d = base_q + ADDR_WIDTH'(in_bytes);
                rp_d   = (in_mode == MODE_ALPHA) && (in_rpt > RW'(1));
            end else begin
                row_d = row_inc[CNT_WIDTH-1:0];
            end
        end else if (byte_tick) begin
            if (line_full) begin
                ovr_d = 1'b1;
            end else begin
                idx_d = idx_inc;
            end
        end
    end

    // Address is registered from next-state so DA moves one cycle
    // after the strobe, with no extra pipeline stage.
    assign da_d = base_d + idx_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_ALPHA;
            base_q <= '0;
            idx_q  <= '0;
            row_q  <= '0;
            da_q   <= '0;
            rp_q   <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            base_q <= base_d;
            idx_q  <= idx_d;
            row_q  <= row_d;
            da_q   <= da_d;
            rp_q   <= rp_d;
            ovr_q  <= ovr_d;
        end
    end

    assign DA      = da_q;
    assign row     = row_q;
    assign RP      = rp_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_vdg_address_generator.sv
// Self-checking bench for vdg_address_generator.
// Vector table, directed corner sequences and random strobes vs a model.
module tb_vdg_address_generator;

    localparam int AW   = 13;
    localparam int AMOD = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          frame_start = 1'b0;
    logic          line_end = 1'b0;
    logic          byte_tick = 1'b0;
    logic          AnG = 1'b0;
    logic [2:0]    GM = 3'd0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] DA;
    logic [3:0]    row;
    logic          RP;
    logic          overrun;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    vdg_address_generator dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .line_end   (line_end),
        .byte_tick  (byte_tick),
        .AnG        (AnG),
        .GM         (GM),
        .start_addr (start_addr),
        .DA         (DA),
        .row        (row),
        .RP         (RP),
        .overrun    (overrun)
    );

    // Reference model: plain integers following the mode table rules
    int GM_BYTES [8] = '{16, 16, 32, 16, 32, 16, 32, 32};
    int GM_REP   [8] = '{3, 3, 3, 2, 2, 1, 1, 1};

    bit m_ang = 0;
    int m_gm = 0;
    int m_base = 0;
    int m_idx = 0;
    int m_row = 0;
    bit m_rp = 0;
    bit m_ov = 0;

    function automatic int bytes_of(bit ang, int gm);
        return ang ? GM_BYTES[gm] : 32;
    endfunction

    function automatic int rep_of(bit ang, int gm);
        return ang ? GM_REP[gm] : 12;
    endfunction

    task automatic model(input bit r, fs, le, bt, ang, input int gm, input int sa);
        m_rp = 0;
        m_ov = 0;
        if (r) begin
            m_ang = 0; m_gm = 0; m_base = 0; m_idx = 0; m_row = 0;
        end else if (fs) begin
            m_ang = ang; m_gm = gm; m_idx = 0; m_row = 0;
`ifdef VDG_START_OFFSET_EN
            m_base = sa;
`else
            m_base = 0;
`endif
        end else if (le) begin
            m_ang = ang; m_gm = gm; m_idx = 0;
            if (m_row + 1 >= rep_of(ang, gm)) begin
                m_row = 0;
                m_base = (m_base + bytes_of(ang, gm)) % AMOD;
                m_rp = !ang && (rep_of(ang, gm) > 1);
            end else begin
                m_row = m_row + 1;
            end
        end else if (bt) begin
            if (m_idx >= bytes_of(m_ang, m_gm) - 1) m_ov = 1;
            else m_idx = m_idx + 1;
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, fs, le, bt, ang, input bit [2:0] gm,
                        input bit [AW-1:0] sa);
        int eda;
        @(negedge clk);
        reset = r; frame_start = fs; line_end = le; byte_tick = bt;
        AnG = ang; GM = gm; start_addr = sa;
        @(posedge clk);
        #1;
        model(r, fs, le, bt, ang, int'(gm), int'(sa));
        eda = (m_base + m_idx) % AMOD;
        n_vec++;
        if (int'(DA) !== eda || int'(row) !== m_row || RP !== m_rp || overrun !== m_ov) begin
            n_miss++;
            $display("FAIL model: DA=%0d row=%0d RP=%0b ov=%0b expected DA=%0d row=%0d RP=%0b ov=%0b at %0t",
                     DA, row, RP, overrun, eda, m_row, m_rp, m_ov, $time);
        end
    endtask

    task automatic idle(input bit ang, input bit [2:0] gm);
        step(0, 0, 0, 0, ang, gm, '0);
    endtask

    typedef struct {
        bit       rst, fs, le, bt, ang;
        bit [2:0] gm;
        int       da, rw;
        bit       rp, ov;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int ovc;
        int rpc;
        bit r_ang;
        bit [2:0] r_gm;

        // rst fs le bt ang gm | DA row RP ov
        tbl.push_back('{1, 0, 0, 0, 0, 3'd0,  0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 1, 3'd7,  0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 1, 3'd7,  1, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 1, 3'd7,  2, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 1, 3'd7, 32, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 1, 3'd7, 33, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 1, 3'd7,  0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 3'd0,  0, 1, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 3'd0,  0, 2, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0, 3'd0,  1, 2, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 1, 3'd0,  0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 1, 3'd0,  0, 1, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 1, 3'd0,  0, 2, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 1, 3'd0, 16, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 1, 3'd5, 32, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 3'd0, 32, 1, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 1, 3'd6, 64, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 1, 3'd6, 65, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 3'd0, 64, 1, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 0, 3'd0,  0, 0, 0, 0});

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].fs, tbl[i].le, tbl[i].bt, tbl[i].ang, tbl[i].gm, '0);
            chk($sformatf("tbl%0d_da", i), int'(DA), tbl[i].da);
            chk($sformatf("tbl%0d_row", i), int'(row), tbl[i].rw);
            chk($sformatf("tbl%0d_rp", i), int'(RP), int'(tbl[i].rp));
            chk($sformatf("tbl%0d_ov", i), int'(overrun), int'(tbl[i].ov));
        end

        // GM7 full frame: 192 lines of 32 bytes
        step(0, 1, 0, 0, 1, 3'd7, '0);
        chk("gm7_first", int'(DA), 0);
        for (int l = 0; l < 192; l++) begin
            for (int b = 0; b < 32; b++) step(0, 0, 0, 1, 1, 3'd7, '0);
            chk("gm7_line_last", int'(DA), l * 32 + 31);
            step(0, 0, 1, 0, 1, 3'd7, '0);
        end
        chk("gm7_after_192", int'(DA), 6144);

        // GM0: three repeats of 16 bytes, then advance by 16
        step(0, 1, 0, 0, 1, 3'd0, '0);
        for (int l = 0; l < 3; l++) begin
            for (int b = 0; b < 16; b++) begin
                chk("gm0_da", int'(DA), b);
                if (b < 15) step(0, 0, 0, 1, 1, 3'd0, '0);
            end
            step(0, 0, 1, 0, 1, 3'd0, '0);
        end
        chk("gm0_line4", int'(DA), 16);

        // Alpha: 12 line_end -> row wraps, single RP, base 32
        step(0, 1, 0, 0, 0, 3'd0, '0);
        rpc = 0;
        for (int i = 1; i <= 12; i++) begin
            step(0, 0, 1, 0, 0, 3'd0, '0);
            rpc += int'(RP);
            chk("alpha_row", int'(row), i % 12);
        end
        chk("alpha_rp_on_12th", int'(RP), 1);
        chk("alpha_rp_count", rpc, 1);
        chk("alpha_base", int'(DA), 32);
        idle(0, 3'd0);
        chk("alpha_rp_clear", int'(RP), 0);

        // Overrun in a 32-byte line
        step(0, 1, 0, 0, 1, 3'd6, '0);
        ovc = 0;
        for (int i = 0; i < 31; i++) begin
            step(0, 0, 0, 1, 1, 3'd6, '0);
            ovc += int'(overrun);
        end
        chk("ovr_none_yet", ovc, 0);
        chk("ovr_da31", int'(DA), 31);
        step(0, 0, 0, 1, 1, 3'd6, '0);
        chk("ovr_pulse", int'(overrun), 1);
        chk("ovr_da_hold", int'(DA), 31);
        idle(1, 3'd6);
        chk("ovr_clear", int'(overrun), 0);
        step(0, 0, 0, 1, 1, 3'd6, '0);
        chk("ovr_da_hold2", int'(DA), 31);

        // frame_start beats line_end; reset mid-line
        step(0, 0, 1, 0, 1, 3'd4, '0);
        step(0, 0, 0, 1, 1, 3'd4, '0);
        step(0, 1, 1, 0, 1, 3'd4, '0);
        chk("fs_le_da", int'(DA), 0);
        chk("fs_le_row", int'(row), 0);
        step(0, 0, 1, 0, 0, 3'd0, '0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 3'd0, '0);
        chk("pre_rst_row", int'(row), 1);
        step(1, 0, 0, 1, 0, 3'd0, '0);
        chk("rst_da", int'(DA), 0);
        chk("rst_row", int'(row), 0);
        chk("rst_rp", int'(RP), 0);
        chk("rst_ov", int'(overrun), 0);

        // Frame start offset
        step(0, 1, 0, 0, 1, 3'd6, 13'h1FF0);
`ifdef VDG_START_OFFSET_EN
        chk("ofs_start", int'(DA), 'h1FF0);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 1, 3'd6, '0);
        chk("ofs_top", int'(DA), 'h1FFF);
        step(0, 0, 0, 1, 1, 3'd6, '0);
        chk("ofs_wrap", int'(DA), 0);
        step(0, 0, 1, 0, 1, 3'd6, '0);
        chk("ofs_line2", int'(DA), 'h0010);
`else
        chk("nofs_start", int'(DA), 0);
        step(0, 0, 1, 0, 1, 3'd6, '0);
        chk("nofs_line2", int'(DA), 32);
`endif

        // Random strobes and mode changes
        r_ang = 1;
        r_gm = 3'd0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(49) == 0) begin
                r_ang = 1'($urandom_range(1));
                r_gm = 3'($urandom_range(7));
            end
            step($urandom_range(299) == 0, $urandom_range(99) == 0,
                 $urandom_range(44) == 0, $urandom_range(1) == 1,
                 r_ang, r_gm, 13'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
